// File: rtl/sram_rd_stream.sv
// rtl/sram_rd_stream.sv - address-beat stream to SRAM read data stream with 3-entry credit-checked output buffer
// One-cycle-latency SRAM read; sideband rides alongside the in-flight read and is rejoined at capture.
module sram_rd_stream #(
  parameter int AW  = 11,
  parameter int DW  = 32,
  parameter int IFW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [AW-1:0]  a_addr,
  input  logic [IFW-1:0] a_info,
  input  logic           a_first,
  input  logic           a_last,
  input  logic           a_valid,
  output logic           a_ready,
  output logic           mem_cs,
  output logic [AW-1:0]  mem_addr,
  input  logic [DW-1:0]  mem_rdata,
  output logic [DW-1:0]  m_data,
  output logic [IFW-1:0] m_info,
  output logic           m_first,
  output logic           m_last,
  output logic           m_valid,
  input  logic           m_ready,
  output logic           burst_done
);

  localparam int EW = DW + IFW + 2;
  localparam int SW = IFW + 2;

  logic [EW-1:0] fifo_q [3];
  logic [1:0]    wr_ptr_q, wr_ptr_d;
  logic [1:0]    rd_ptr_q, rd_ptr_d;
  logic [1:0]    occ_q, occ_d;
  logic          inflight_q, inflight_d;
  logic [SW-1:0] pend_q, pend_d;
  logic          burst_done_q, burst_done_d;

  logic [2:0] credits_used;
  logic       accept;
  logic       push;
  logic       pop;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Credits count buffered beats plus the read still in the SRAM pipe, so a push never overflows.
  assign credits_used = {1'b0, occ_q} + {2'b00, inflight_q};
  assign a_ready      = !rst && (credits_used < 3'd3);
  assign accept       = a_valid && a_ready;
  assign mem_cs       = accept;
  assign mem_addr     = a_addr;

  assign push    = inflight_q;
  assign m_valid = (occ_q != 2'd0);
  assign pop     = m_valid && m_ready;

  assign {m_data, m_info, m_first, m_last} = m_valid ? fifo_q[rd_ptr_q] : '0;
  assign burst_done = burst_done_q;

  always_comb begin
    occ_d        = occ_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    inflight_d   = accept;
    pend_d       = pend_q;
    burst_done_d = pop && m_last;

    if (accept) begin
      pend_d = {a_info, a_first, a_last};
    end
    if (push) begin
      wr_ptr_d = next_ptr(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q        <= 2'd0;
      wr_ptr_q     <= 2'd0;
      rd_ptr_q     <= 2'd0;
      inflight_q   <= 1'b0;
      pend_q       <= '0;
      burst_done_q <= 1'b0;
    end else begin
      occ_q        <= occ_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      inflight_q   <= inflight_d;
      pend_q       <= pend_d;
      burst_done_q <= burst_done_d;
    end
  end

  // Storage needs no reset: the outputs are masked whenever the buffer is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= {mem_rdata, pend_q};
    end
  end

endmodule

// File: tb/tb_sram_rd_stream.sv
// tb/tb_sram_rd_stream.sv - scoreboard bench for sram_rd_stream
module tb_sram_rd_stream;
  localparam int AW  = 11;
  localparam int DW  = 32;
  localparam int IFW = 8;

  typedef struct packed {
    logic [DW-1:0]  data;
    logic [IFW-1:0] info;
    logic           first;
    logic           last;
  } beat_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [AW-1:0]  a_addr = '0;
  logic [IFW-1:0] a_info = '0;
  logic           a_first = 1'b0;
  logic           a_last = 1'b0;
  logic           a_valid = 1'b0;
  logic           a_ready;
  logic           mem_cs;
  logic [AW-1:0]  mem_addr;
  logic [DW-1:0]  mem_rdata = '0;
  logic [DW-1:0]  m_data;
  logic [IFW-1:0] m_info;
  logic           m_first;
  logic           m_last;
  logic           m_valid;
  logic           m_ready = 1'b0;
  logic           burst_done;

  sram_rd_stream #(.AW(AW), .DW(DW), .IFW(IFW)) dut (
    .clk(clk), .rst(rst),
    .a_addr(a_addr), .a_info(a_info), .a_first(a_first), .a_last(a_last),
    .a_valid(a_valid), .a_ready(a_ready),
    .mem_cs(mem_cs), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .m_data(m_data), .m_info(m_info), .m_first(m_first), .m_last(m_last),
    .m_valid(m_valid), .m_ready(m_ready), .burst_done(burst_done)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] sram_word(input logic [AW-1:0] addr);
    return DW'(addr) * 32'd3;
  endfunction

  always @(posedge clk) if (mem_cs) mem_rdata <= sram_word(mem_addr);

  beat_t sb[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    mem_cs_cnt = 0, bd_cnt = 0, hs_cnt = 0;
  int    rise_cyc = 0, acc_cyc = 0, first_hs_cyc = 0, last_hs_cyc = 0;
  int    ready_mode = 1;
  logic  bd_exp = 1'b0, prev_hold = 1'b0, prev_mv = 1'b0;
  beat_t held;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // 0: hold low, 1: hold high, 2: random 50%
  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      0:       m_ready = 1'b0;
      1:       m_ready = 1'b1;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (rst) begin
      bd_exp = 1'b0; prev_hold = 1'b0; prev_mv = 1'b0;
    end else begin
      chk("a_ready_credit", 64'(a_ready), 64'(sb.size() < 3));
      chk("outstanding_le3", 64'(sb.size() <= 3), 64'd1);
      if (prev_hold) begin
        chk("hold_valid", 64'(m_valid), 64'd1);
        chk("hold_stable", 64'({m_data, m_info, m_first, m_last}), 64'(held));
      end
      if (burst_done || bd_exp) chk("burst_done", 64'(burst_done), 64'(bd_exp));
      if (burst_done) bd_cnt++;
      if (mem_cs) mem_cs_cnt++;
      if (m_valid && !prev_mv) rise_cyc = cyc;
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: got data %0h expected no beat", m_data);
        end else begin
          beat_t e;
          e = sb.pop_front();
          chk("beat", 64'({m_data, m_info, m_first, m_last}), 64'(e));
        end
        hs_cnt++;
        if (hs_cnt == 1) first_hs_cyc = cyc;
        last_hs_cyc = cyc;
      end
      bd_exp    = m_valid && m_ready && m_last;
      prev_hold = m_valid && !m_ready;
      held      = {m_data, m_info, m_first, m_last};
      prev_mv   = m_valid;
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send_beat(input logic [AW-1:0] addr, input logic [IFW-1:0] info,
                           input logic first, input logic last);
    beat_t b;
    a_addr = addr; a_info = info; a_first = first; a_last = last; a_valid = 1'b1;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk); #1;
      if (a_ready) begin
        b.data = sram_word(addr); b.info = info; b.first = first; b.last = last;
        sb.push_back(b);
        acc_cyc = cyc;
        @(posedge clk); #1;
        a_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    checks++; errors++;
    $display("FAIL accept_timeout: addr %0h never accepted", addr);
    a_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL drain_timeout: %0d beats outstanding, expected 0", sb.size());
    @(posedge clk); #1;
  endtask

  initial begin
    int first_acc, bd0, cs0, n;
    repeat (3) @(posedge clk);
    #2;
    a_valid = 1'b1;
    #1;
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_a_ready", 64'(a_ready), 64'd0);
    chk("rst_mem_cs", 64'(mem_cs), 64'd0);
    chk("rst_m_data", 64'({m_data, m_info, m_first, m_last}), 64'd0);
    chk("rst_burst_done", 64'(burst_done), 64'd0);
    a_valid = 1'b0;
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    chk("release_a_ready", 64'(a_ready), 64'd1);
    @(posedge clk); #1;

    // full-rate 4-beat burst
    hs_cnt = 0; bd0 = bd_cnt;
    send_beat(11'h010, 8'h5A, 1'b1, 1'b0);
    first_acc = acc_cyc;
    send_beat(11'h012, 8'h5A, 1'b0, 1'b0);
    send_beat(11'h014, 8'h5A, 1'b0, 1'b0);
    send_beat(11'h016, 8'h5A, 1'b0, 1'b1);
    wait_drain();
    chk("t1_latency", 64'(rise_cyc - first_acc), 64'd2);
    chk("t1_beats", 64'(hs_cnt), 64'd4);
    chk("t1_span", 64'(last_hs_cyc - first_hs_cyc), 64'd3);
    chk("t1_done", 64'(bd_cnt - bd0), 64'd1);

    // stall then release
    ready_mode = 0;
    repeat (2) begin @(posedge clk); #1; end
    hs_cnt = 0; cs0 = mem_cs_cnt;
    fork
      for (int i = 0; i < 8; i++)
        send_beat(11'(11'h200 + i * 4), 8'h33, 1'(i == 0), 1'(i == 7));
      begin
        repeat (6) @(negedge clk);
        #2;
        chk("t2_cs_stalled", 64'(mem_cs_cnt - cs0), 64'd3);
        chk("t2_a_ready_low", 64'(a_ready), 64'd0);
        ready_mode = 1;
      end
    join
    wait_drain();
    chk("t2_beats", 64'(hs_cnt), 64'd8);
    chk("t2_cs_total", 64'(mem_cs_cnt - cs0), 64'd8);

    // random backpressure and gaps
    ready_mode = 2; hs_cnt = 0; n = 0;
    while (n < 500) begin
      int len;
      logic [IFW-1:0] inf;
      len = $urandom_range(1, 4);
      inf = 8'($urandom);
      for (int i = 0; i < len && n < 500; i++) begin
        send_beat(11'($urandom_range(0, 2047)), inf, 1'(i == 0), 1'(i == len - 1 || n == 499));
        n++;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
    end
    ready_mode = 1;
    wait_drain();
    chk("t3_beats", 64'(hs_cnt), 64'd500);

    // single-beat burst
    bd0 = bd_cnt; hs_cnt = 0;
    send_beat(11'h7FF, 8'hC3, 1'b1, 1'b1);
    wait_drain();
    chk("t4_beats", 64'(hs_cnt), 64'd1);
    chk("t4_done", 64'(bd_cnt - bd0), 64'd1);

    // reset with two buffered beats and one read in flight
    ready_mode = 0;
    repeat (2) begin @(posedge clk); #1; end
    send_beat(11'h300, 8'h11, 1'b1, 1'b0);
    send_beat(11'h301, 8'h11, 1'b0, 1'b0);
    send_beat(11'h302, 8'h11, 1'b0, 1'b0);
    chk("t5_pre_valid", 64'(m_valid), 64'd1);
    a_addr = 11'h3F0; a_valid = 1'b1;
    #1;
    rst = 1'b1;
    sb.delete();
    #1;
    chk("t5_m_valid", 64'(m_valid), 64'd0);
    chk("t5_a_ready", 64'(a_ready), 64'd0);
    chk("t5_mem_cs", 64'(mem_cs), 64'd0);
    chk("t5_m_data", 64'({m_data, m_info, m_first, m_last}), 64'd0);
    @(posedge clk); @(posedge clk); #3;
    a_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("t5_release_a_ready", 64'(a_ready), 64'd1);
    ready_mode = 1;
    repeat (5) begin @(posedge clk); #1; end
    chk("t5_no_stale", 64'(m_valid), 64'd0);
    hs_cnt = 0;
    send_beat(11'h100, 8'h77, 1'b1, 1'b0);
    first_acc = acc_cyc;
    send_beat(11'h101, 8'h77, 1'b0, 1'b1);
    wait_drain();
    chk("t5_latency", 64'(rise_cyc - first_acc), 64'd2);
    chk("t5_beats", 64'(hs_cnt), 64'd2);

    // back-to-back bursts
    hs_cnt = 0; bd0 = bd_cnt;
    send_beat(11'h020, 8'h01, 1'b1, 1'b0);
    send_beat(11'h021, 8'h01, 1'b0, 1'b1);
    send_beat(11'h040, 8'h02, 1'b1, 1'b0);
    send_beat(11'h041, 8'h02, 1'b0, 1'b0);
    send_beat(11'h042, 8'h02, 1'b0, 1'b1);
    wait_drain();
    chk("t6_beats", 64'(hs_cnt), 64'd5);
    chk("t6_span", 64'(last_hs_cyc - first_hs_cyc), 64'd4);
    chk("t6_done", 64'(bd_cnt - bd0), 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

endmodule
